call_request_latch: RTL
=======================

Name: call_request_latch

Overview:
- Sits directly downstream of the per-button debouncers and upstream of the elevator control FSM.
- Takes one debounced, already-synchronised level per floor call button and converts each rising edge into a sticky pending request.
- Holds each request until the FSM reports that floor as serviced.
- Publishes registered direction summary flags (above / below / here / any) relative to the car's current floor, so the FSM never scans the bitmap itself.

Parameters:
- NUM_FLOORS, 4, number of floors and call buttons (2..16).
- FLOOR_W, 2, width of floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST  input  1  asynchronous, active-high reset.
- btn_db  input  NUM_FLOORS  debounced button levels, one per floor, already synchronous to CLK.
- cur_floor  input  FLOOR_W  current car floor, from the FSM.
- clr_valid  input  1  single-cycle strobe: the floor given by clr_floor has been serviced.
- clr_floor  input  FLOOR_W  floor to clear; qualified by clr_valid.
- press_pulse  output  NUM_FLOORS  one-cycle pulse per detected press.
- req_pending  output  NUM_FLOORS  sticky request bitmap; also drives the call LEDs.
- req_any  output  1  at least one request is pending.
- req_above  output  1  a request is pending at an index greater than cur_floor.
- req_below  output  1  a request is pending at an index less than cur_floor.
- req_here  output  1  a request is pending at cur_floor.

Behaviour:
- Reset (async, RST=1):
  - btn_prev, press_pulse, req_pending and all four flags go to 0 immediately.
  - All of these hold 0 while RST is high.
- Edge detect:
  - btn_prev <= btn_db every cycle.
  - rise = btn_db & ~btn_prev.
  - press_pulse <= rise, registered, so the pulse appears 1 cycle after the edge is sampled.
  - A button held across reset release produces exactly one press, because btn_prev resets to 0.
- Pending update, every cycle:
  - req_pending <= (req_pending | rise) & ~clr_mask.
  - clr_mask is one-hot at clr_floor when clr_valid=1, otherwise 0.
- Latency:
  - A btn_db edge sampled at cycle t gives press_pulse=1 and req_pending bit=1 at t+1.
  - Summary flags reflect it at t+2.
  - A clear at t drops the pending bit at t+1 and the flags at t+2.
- Flags:
  - Computed from the registered req_pending and the current cur_floor, then registered.
  - This gives one cycle of lag relative to req_pending.
  - req_any = OR of req_pending, independent of cur_floor.
- Simultaneous events:
  - A rise and a clear on the same floor in the same cycle: the clear wins and the bit ends at 0. The passenger is treated as served by the open door.
  - press_pulse still fires in that case.
  - A rise on one floor and a clear on another: both take effect.
- Out-of-range indices:
  - clr_floor >= NUM_FLOORS with clr_valid=1: ignored, no bit changes.
  - cur_floor >= NUM_FLOORS: req_here=0, req_above=0, req_below = req_any.
- Re-press of an already-pending floor: no state change; press_pulse still fires.
- Held button: exactly one press_pulse per rising edge, regardless of hold length.
- No FSM inside the block. State consists of btn_prev, req_pending and the flag registers.

Decomposition:
- Shared package elevator_pkg holds NUM_FLOORS, FLOOR_W and the floor index typedef. The debouncer and control FSM use the same package.
- One natural sub-module: req_scan.
  - Purely combinational.
  - Inputs: req_pending and cur_floor.
  - Outputs: above / below / here / any, built with per-index compare masks.
  - The top level registers its outputs.

Test Plan:
- Reset then btn_db=4'b0100 from cycle 5:
  - press_pulse=4'b0100 at cycle 6 only.
  - req_pending=4'b0100 from cycle 6.
  - With cur_floor=0: req_above=1 and req_any=1 from cycle 7.
- Pending=4'b1001, cur_floor=2 -> req_above=1, req_below=1, req_here=0.
  - Then clr_valid with clr_floor=3 -> pending=4'b0001 next cycle, req_above=0 one cycle later.
- Same cycle: rise on floor 1 and clr_valid with clr_floor=1 -> press_pulse[1]=1, req_pending[1]=0.
- Hold btn_db[0] high for 1000 cycles -> exactly one press_pulse[0]; clr_valid on floor 0 mid-hold -> bit stays 0 (no re-latch).
- clr_valid with clr_floor=3 when NUM_FLOORS=3 -> pending unchanged.
  - Then cur_floor=3 with pending=3'b011 -> req_below=1, req_here=0, req_above=0.
- Assert RST asynchronously mid-clock while pending=4'b1111 -> all outputs 0 before the next CLK edge.
  - After release with btn_db=4'b0010 held -> press_pulse[1] fires once.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor index type and the
// direction summary record published to the control FSM.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef struct packed {
    logic any;
    logic above;
    logic below;
    logic here;
  } req_flags_t;

endpackage

// File: rtl/call_request_latch_if.sv
// Call-button / request bundle between the request latch (slave) and the
// elevator control FSM that drives floor and service information (master).
interface call_request_latch_if #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);

  logic [NUM_FLOORS-1:0] btn_db;
  logic [FLOOR_W-1:0]    cur_floor;
  logic                  clr_valid;
  logic [FLOOR_W-1:0]    clr_floor;
  logic [NUM_FLOORS-1:0] press_pulse;
  logic [NUM_FLOORS-1:0] req_pending;
  logic                  req_any;
  logic                  req_above;
  logic                  req_below;
  logic                  req_here;

  modport master (
    output btn_db, cur_floor, clr_valid, clr_floor,
    input  press_pulse, req_pending, req_any, req_above, req_below, req_here
  );

  modport slave (
    input  btn_db, cur_floor, clr_valid, clr_floor,
    output press_pulse, req_pending, req_any, req_above, req_below, req_here
  );

endinterface

// File: rtl/call_request_latch_req_scan.sv
// Combinational direction summary of the pending-request bitmap relative to
// the car's floor. A floor index beyond the shaft counts every request as below.
module req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] req_pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output req_flags_t            flags
);

  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] here_mask;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    above_mask = '0;
    below_mask = '0;
    here_mask  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = FLOOR_W'(i) > cur_floor;
      below_mask[i] = FLOOR_W'(i) < cur_floor;
      here_mask[i]  = FLOOR_W'(i) == cur_floor;
    end
    flags.any   = |req_pending;
    flags.above = |(req_pending & above_mask);
    flags.below = |(req_pending & below_mask);
    flags.here  = |(req_pending & here_mask);
  end

endmodule

// File: rtl/call_request_latch.sv
// Turns debounced call-button rises into sticky floor requests, cleared when
// the FSM reports a floor serviced, and publishes registered direction flags.
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input logic                CLK,
  input logic                RST,
  call_request_latch_if.slave bus
);

  logic [NUM_FLOORS-1:0] btn_prev_q,    btn_prev_d;
  logic [NUM_FLOORS-1:0] press_pulse_q, press_pulse_d;
  logic [NUM_FLOORS-1:0] req_pending_q, req_pending_d;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] clr_mask;
  req_flags_t            flags_q, flags_d, scan_flags;

  req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_req_scan (
    .req_pending (req_pending_q),
    .cur_floor   (bus.cur_floor),
    .flags       (scan_flags)
  );

  always_comb begin
    rise     = bus.btn_db & ~btn_prev_q;
    clr_mask = '0;
    // Out-of-range clr_floor matches no index, so the clear is dropped.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_mask[i] = bus.clr_valid && (bus.clr_floor == FLOOR_W'(i));
    end
    btn_prev_d    = bus.btn_db;
    press_pulse_d = rise;
    // Clear wins over a same-cycle press: the open door serves that passenger.
    req_pending_d = (req_pending_q | rise) & ~clr_mask;
    flags_d       = scan_flags;
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      btn_prev_q    <= '0;
      press_pulse_q <= '0;
      req_pending_q <= '0;
      flags_q       <= '0;
    end else begin
      btn_prev_q    <= btn_prev_d;
      press_pulse_q <= press_pulse_d;
      req_pending_q <= req_pending_d;
      flags_q       <= flags_d;
    end
  end

  assign bus.press_pulse = press_pulse_q;
  assign bus.req_pending = req_pending_q;
  assign bus.req_any     = flags_q.any;
  assign bus.req_above   = flags_q.above;
  assign bus.req_below   = flags_q.below;
  assign bus.req_here    = flags_q.here;

endmodule
